// File: rtl/exp7_detector_jogada.sv
// rtl/exp7_detector_jogada.sv - button synchronizer, debouncer and one-hot play detector
//
// Optional build macro: JOGADA_INVALIDA_EN adds the jogada_invalida port.
//
// Ports:
//   clock           system clock, single domain
//   reset           synchronous, active-high reset
//   botoes          raw asynchronous button levels, 1 = pressed
//   habilita        1 = a new play may be accepted
//   jogada_feita    one-cycle pulse when a valid play is accepted
//   jogada          one-hot code of the last accepted play, held until the next one
//   db_estado       current FSM state code, for debug
//   jogada_invalida (JOGADA_INVALIDA_EN only) one-cycle pulse on a rejected multi-button press

module exp7_detector_jogada #(
   parameter int N_BOTOES        = 4,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [N_BOTOES-1:0] botoes,
   input  logic                habilita,
   output logic                jogada_feita,
   output logic [N_BOTOES-1:0] jogada,
   output logic [2:0]          db_estado
`ifdef JOGADA_INVALIDA_EN
   ,
   output logic                jogada_invalida
`endif
);

   localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [2:0] {
      OCIOSO         = 3'd0,
      DEBOUNCE_PRESS = 3'd1,
      VALIDA         = 3'd2,
      REJEITA        = 3'd3,
      ESPERA_SOLTAR  = 3'd4,
      DEBOUNCE_SOLTA = 3'd5
   } estado_t;

   estado_t             estado;
   estado_t             proximo;
   logic [N_BOTOES-1:0] sync1;
   logic [N_BOTOES-1:0] sync2;
   logic [N_BOTOES-1:0] padrao;
   logic [N_BOTOES-1:0] padrao_next;
   logic [N_BOTOES-1:0] jogada_next;
   logic [CW-1:0]       cnt;
   logic [CW-1:0]       cnt_next;

   function automatic logic is_onehot(input logic [N_BOTOES-1:0] v);
      return (v != '0) && ((v & (v - N_BOTOES'(1))) == '0);
   endfunction

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1  <= '0;
         sync2  <= '0;
         estado <= OCIOSO;
         padrao <= '0;
         cnt    <= '0;
         jogada <= '0;
      end else begin
         sync1  <= botoes;
         sync2  <= sync1;
         estado <= proximo;
         padrao <= padrao_next;
         cnt    <= cnt_next;
         jogada <= jogada_next;
      end
   end

   always_comb begin
      proximo     = estado;
      padrao_next = padrao;
      cnt_next    = cnt;
      jogada_next = jogada;
      case (estado)
         OCIOSO: begin
            if (habilita && (sync2 != '0)) begin
               proximo     = DEBOUNCE_PRESS;
               padrao_next = sync2;
               cnt_next    = '0;
            end
         end
         DEBOUNCE_PRESS: begin
            if (!habilita) begin
               // Aborted play: the button must be released before a new one counts.
               proximo = ESPERA_SOLTAR;
            end else if (sync2 != padrao) begin
               if (sync2 == '0) begin
                  proximo = OCIOSO;
               end else begin
                  padrao_next = sync2;
                  cnt_next    = '0;
               end
            end else if (cnt == CNT_MAX) begin
               if (is_onehot(padrao)) begin
                  proximo     = VALIDA;
                  // Load on entry so jogada is already valid while the pulse is high.
                  jogada_next = padrao;
               end else begin
                  proximo = REJEITA;
               end
            end else begin
               cnt_next = cnt + CW'(1);
            end
         end
         VALIDA: begin
            proximo = ESPERA_SOLTAR;
         end
         REJEITA: begin
            proximo = ESPERA_SOLTAR;
         end
         ESPERA_SOLTAR: begin
            if (sync2 == '0) begin
               proximo  = DEBOUNCE_SOLTA;
               cnt_next = '0;
            end
         end
         DEBOUNCE_SOLTA: begin
            if (sync2 != '0) begin
               proximo = ESPERA_SOLTAR;
            end else if (cnt == CNT_MAX) begin
               proximo = OCIOSO;
            end else begin
               cnt_next = cnt + CW'(1);
            end
         end
         default: begin
            proximo = OCIOSO;
         end
      endcase
   end

   assign jogada_feita = (estado == VALIDA);
   assign db_estado    = estado;

`ifdef JOGADA_INVALIDA_EN
   assign jogada_invalida = (estado == REJEITA);
`endif

endmodule
